// File: rtl/spi_stream_pkg.sv
// spi_stream_pkg: shared constants and state type for the SPI stream front-end.
//   - Register-port addresses of the 16-bit SPI master core.
//   - Control register SSO bit index.
//   - State enum for the spi_stream_master sequencer.
package spi_stream_pkg;

    localparam logic [2:0] ADDR_RXDATA   = 3'd0;
    localparam logic [2:0] ADDR_TXDATA   = 3'd1;
    localparam logic [2:0] ADDR_STATUS   = 3'd2;
    localparam logic [2:0] ADDR_CONTROL  = 3'd3;
    localparam logic [2:0] ADDR_SLAVESEL = 3'd5;

    localparam int CTRL_SSO = 10;

    typedef enum logic [3:0] {
        INIT_SS,
        IDLE,
        WAIT_TX,
        WR_DATA,
        GAP,
        WAIT_RX,
        RD_DATA,
        GAP2,
        SSO_SET,
        SSO_CLR,
        SSO_GAP
    } state_e;

endpackage

// File: rtl/spi_stream_fifo.sv
// spi_stream_fifo: small synchronous FIFO holding received SPI words.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset (pointers only)
//   push / din         write din when not full
//   pop / dout         advance head when not empty; dout shows head combinationally
//   empty, full, count occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module spi_stream_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q;
    logic [AW:0]       rptr_q;
    logic              do_push;
    logic              do_pop;

    assign count   = wptr_q - rptr_q;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_stream_master.sv
// spi_stream_master: drives the SPI master register port from a TX stream and
// returns each received word on an RX stream through spi_stream_fifo.
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   tx_valid/tx_data/tx_last/tx_ready  TX word stream (tx_last used with SSO hold)
//   rx_valid/rx_data/rx_ready          RX word stream (head of RX FIFO)
//   busy                               sequencer not in IDLE
//   spi_*                              SPI core register port
// Build option: define SPI_SSO_HOLD_EN to keep SS_n low across a packet by
// setting the control SSO bit before the first word and clearing it after the
// word flagged tx_last.
//
// state   | meaning
// INIT_SS | write SLAVE_MASK to slave-enable register
// IDLE    | wait for TX word (only if RX FIFO has room)
// WAIT_TX | wait for TRDY
// WR_DATA | write TX word to addr 1
// GAP     | one idle cycle
// WAIT_RX | wait for RRDY
// RD_DATA | read addr 0, push word into RX FIFO
// GAP2    | one idle cycle so the core can drop RRDY
// SSO_SET | write SSO bit to control register
// SSO_CLR | clear control register
// SSO_GAP | one idle cycle after a control write
module spi_stream_master
    import spi_stream_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter int                RX_DEPTH   = 4,
    parameter logic [DATA_W-1:0] SLAVE_MASK = 16'h0001
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    output logic              tx_ready,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic              busy,
    output logic              spi_select,
    output logic [2:0]        spi_mem_addr,
    output logic              spi_read_n,
    output logic              spi_write_n,
    output logic [DATA_W-1:0] spi_data_from_cpu,
    input  logic [DATA_W-1:0] spi_data_to_cpu,
    input  logic              spi_dataavailable,
    input  logic              spi_readyfordata
);

    state_e            state_q;
    logic [1:0]        ph_q;
    logic              sel_q;
    logic [2:0]        addr_q;
    logic              rd_n_q;
    logic              wr_n_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] txw_q;

    logic              acc_req;
    logic              acc_wr;
    logic [2:0]        acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_done;

    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_full;
    logic [$clog2(RX_DEPTH):0] unused_rx_count;

`ifdef SPI_SSO_HOLD_EN
    logic              open_q;
    logic              last_q;
`else
    logic              unused_tx_last;
    assign unused_tx_last = tx_last;
`endif

    assign spi_select        = sel_q;
    assign spi_mem_addr      = addr_q;
    assign spi_read_n        = rd_n_q;
    assign spi_write_n       = wr_n_q;
    assign spi_data_from_cpu = wdata_q;

    assign busy      = (state_q != IDLE);
    assign tx_ready  = (state_q == IDLE) && !fifo_full;
    assign rx_valid  = !fifo_empty;
    assign acc_done  = acc_req && (ph_q == 2'd2);
    // The read word is captured straight into the FIFO on the edge that ends the access.
    assign fifo_push = (state_q == RD_DATA) && acc_done;

    always_comb begin
        acc_req  = 1'b0;
        acc_wr   = 1'b1;
        acc_addr = ADDR_RXDATA;
        acc_data = '0;
        case (state_q)
            INIT_SS: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_SLAVESEL;
                acc_data = SLAVE_MASK;
            end
            WR_DATA: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_TXDATA;
                acc_data = txw_q;
            end
            RD_DATA: begin
                acc_req  = 1'b1;
                acc_wr   = 1'b0;
                acc_addr = ADDR_RXDATA;
            end
            SSO_SET: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_CONTROL;
                acc_data = DATA_W'(1) << CTRL_SSO;
            end
            SSO_CLR: begin
                acc_req  = 1'b1;
                acc_addr = ADDR_CONTROL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= INIT_SS;
            ph_q    <= 2'd0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            wdata_q <= '0;
            txw_q   <= '0;
`ifdef SPI_SSO_HOLD_EN
            open_q  <= 1'b0;
            last_q  <= 1'b0;
`endif
        end else begin
            // Access phases: 0 = drive bus, 1 and 2 = bus held, end of 2 = release.
            if (acc_req) begin
                case (ph_q)
                    2'd0: begin
                        sel_q   <= 1'b1;
                        addr_q  <= acc_addr;
                        wdata_q <= acc_data;
                        wr_n_q  <= !acc_wr;
                        rd_n_q  <= acc_wr;
                        ph_q    <= 2'd1;
                    end
                    2'd1: ph_q <= 2'd2;
                    default: begin
                        sel_q  <= 1'b0;
                        wr_n_q <= 1'b1;
                        rd_n_q <= 1'b1;
                        ph_q   <= 2'd0;
                    end
                endcase
            end

            case (state_q)
                INIT_SS: if (acc_done) state_q <= IDLE;
                IDLE: begin
                    if (tx_valid && !fifo_full) begin
                        txw_q <= tx_data;
`ifdef SPI_SSO_HOLD_EN
                        last_q  <= tx_last;
                        state_q <= open_q ? WAIT_TX : SSO_SET;
`else
                        state_q <= WAIT_TX;
`endif
                    end
                end
                WAIT_TX: if (spi_readyfordata) state_q <= WR_DATA;
                WR_DATA: if (acc_done) state_q <= GAP;
                GAP:     state_q <= WAIT_RX;
                WAIT_RX: if (spi_dataavailable) state_q <= RD_DATA;
                RD_DATA: if (acc_done) state_q <= GAP2;
`ifdef SPI_SSO_HOLD_EN
                GAP2:    state_q <= last_q ? SSO_CLR : IDLE;
                SSO_SET: begin
                    if (acc_done) begin
                        open_q  <= 1'b1;
                        state_q <= SSO_GAP;
                    end
                end
                SSO_CLR: begin
                    if (acc_done) begin
                        open_q  <= 1'b0;
                        state_q <= SSO_GAP;
                    end
                end
                SSO_GAP: state_q <= open_q ? WAIT_TX : IDLE;
`else
                GAP2:    state_q <= IDLE;
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    spi_stream_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (rx_ready),
        .din     (spi_data_to_cpu),
        .dout    (rx_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (unused_rx_count)
    );

endmodule

// File: tb/tb_spi_stream_master.sv
`timescale 1ns/1ps
module tb_spi_stream_master;

    localparam logic [15:0] MASK = 16'h0001;
    typedef logic [19:0] acc_t;   // {is_write, addr, data}

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        tx_valid = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_last = 1'b0;
    logic        tx_ready;
    logic        rx_valid;
    logic [15:0] rx_data;
    logic        rx_ready = 1'b0;
    logic        busy;
    logic        spi_select;
    logic [2:0]  spi_mem_addr;
    logic        spi_read_n;
    logic        spi_write_n;
    logic [15:0] spi_data_from_cpu;
    logic [15:0] spi_data_to_cpu;
    logic        spi_dataavailable;
    logic        spi_readyfordata;

    int vectors = 0;
    int miscompares = 0;

    // SPI core behavioural model
    logic        trdy_m = 1'b1, rrdy_m = 1'b0, toe_m = 1'b0, roe_m = 1'b0;
    logic [15:0] sh_m = '0, rx_reg = '0, ctrl_reg = '0, miso_xor = '0;
    int          word_cnt = 0, n_txw = 0, n_rd = 0, acc_len = 0;
    acc_t        cur_acc = '0;
    logic        win_en = 1'b0;
    int          win_bt = 0, win_br = 0, ss_hi_cnt = 0;
    logic        pkt_open = 1'b0;

    acc_t        log_q[$];
    acc_t        exp_log[$];
    logic [15:0] exp_rx[$];

    assign spi_readyfordata  = trdy_m;
    assign spi_dataavailable = rrdy_m;
    assign spi_data_to_cpu   = (spi_mem_addr == 3'd0) ? rx_reg :
                               (spi_mem_addr == 3'd2) ? {8'h00, rrdy_m, 1'b0, trdy_m, toe_m, roe_m, 3'b000} :
                               16'h0000;

    always #5 clk = ~clk;

    spi_stream_master dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_last           (tx_last),
        .tx_ready          (tx_ready),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .busy              (busy),
        .spi_select        (spi_select),
        .spi_mem_addr      (spi_mem_addr),
        .spi_read_n        (spi_read_n),
        .spi_write_n       (spi_write_n),
        .spi_data_from_cpu (spi_data_from_cpu),
        .spi_data_to_cpu   (spi_data_to_cpu),
        .spi_dataavailable (spi_dataavailable),
        .spi_readyfordata  (spi_readyfordata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor, SPI core model and RX consumer, all sampled on the falling edge.
    initial begin
        acc_t now_acc;
        logic act;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc_len = 0; trdy_m = 1'b1; rrdy_m = 1'b0; word_cnt = 0;
                ctrl_reg = '0; toe_m = 1'b0; roe_m = 1'b0;
            end else begin
                if (word_cnt > 0) begin
                    word_cnt--;
                    if (word_cnt == 0) begin
                        if (rrdy_m) roe_m = 1'b1;
                        rx_reg = sh_m ^ miso_xor;
                        rrdy_m = 1'b1;
                        trdy_m = 1'b1;
                    end
                end
                act = spi_select && (!spi_write_n || !spi_read_n);
                now_acc = {!spi_write_n, spi_mem_addr, (!spi_write_n) ? spi_data_from_cpu : spi_data_to_cpu};
                if (act) begin
                    if (acc_len == 0) cur_acc = now_acc;
                    else check("acc_hold", now_acc, cur_acc);
                    acc_len++;
                end else if (acc_len > 0) begin
                    check("acc_len", acc_len, 2);
                    log_q.push_back(cur_acc);
                    if (cur_acc[19]) begin
                        case (cur_acc[18:16])
                            3'd1: begin
                                if (!trdy_m) toe_m = 1'b1;
                                sh_m = cur_acc[15:0];
                                trdy_m = 1'b0;
                                word_cnt = int'($urandom_range(30, 4));
                                n_txw++;
                            end
                            3'd3: ctrl_reg = cur_acc[15:0];
                            default: ;
                        endcase
                    end else if (cur_acc[18:16] == 3'd0) begin
                        rrdy_m = 1'b0;
                        n_rd++;
                    end
                    acc_len = 0;
                end
                if (win_en && n_txw > win_bt && n_rd < win_br + 3 && !(ctrl_reg[10] || word_cnt > 0))
                    ss_hi_cnt++;
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() == 0) check("rx_unexpected", exp_rx.size(), 1);
                    else check("rx_data", rx_data, exp_rx.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic l);
        int t = 0;
        tx_data = w; tx_last = l; tx_valid = 1'b1;
        @(negedge clk);
        while (!tx_ready && t < 3000) begin t++; @(negedge clk); end
        check("send_timeout", (t >= 3000), 0);
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_last = 1'b0;
`ifdef SPI_SSO_HOLD_EN
        if (!pkt_open) begin exp_log.push_back({1'b1, 3'd3, 16'h0400}); pkt_open = 1'b1; end
`endif
        exp_log.push_back({1'b1, 3'd1, w});
        exp_log.push_back({1'b0, 3'd0, w ^ miso_xor});
        exp_rx.push_back(w ^ miso_xor);
`ifdef SPI_SSO_HOLD_EN
        if (l) begin exp_log.push_back({1'b1, 3'd3, 16'h0000}); pkt_open = 1'b0; end
`endif
    endtask

    task automatic wait_idle(input logic need_empty, input string tag);
        int t = 0;
        @(negedge clk);
        while ((busy || (need_empty && exp_rx.size() != 0)) && t < 5000) begin t++; @(negedge clk); end
        check({tag, "_timeout"}, (t >= 5000), 0);
        @(posedge clk); #1;
    endtask

    task automatic check_log(input string tag);
        check({tag, "_log_len"}, log_q.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            check({tag, "_access"}, log_q[i], exp_log[i]);
        log_q.delete();
        exp_log.delete();
    endtask

    initial begin
        int n_before;
        int t;
        // reset state
        #3 reset_n = 1'b0;
        #10;
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_select", spi_select, 0);
        check("rst_read_n", spi_read_n, 1);
        check("rst_write_n", spi_write_n, 1);
        check("rst_addr", spi_mem_addr, 0);
        check("rst_wdata", spi_data_from_cpu, 0);
        @(posedge clk); #1 reset_n = 1'b1;
        exp_log.push_back({1'b1, 3'd5, MASK});
        repeat (10) @(posedge clk); #1;
        check_log("init");
        check("init_busy", busy, 0);
        check("init_tx_ready", tx_ready, 1);

        // single loopback word
        miso_xor = 16'h0000;
        send(16'hA55A, 1'b0);
        wait_idle(1'b0, "w1");
        check("w1_rx_valid", rx_valid, 1);
        check("w1_rx_data", rx_data, 16'hA55A);
        rx_ready = 1'b1;
        wait_idle(1'b1, "w1_drain");
        rx_ready = 1'b0;
        check("w1_rx_empty", rx_valid, 0);
        check_log("w1");

        // fill the RX FIFO, 5th word must wait for space
        miso_xor = 16'($urandom);
        for (int i = 0; i < 4; i++) send(16'($urandom), 1'b0);
        wait_idle(1'b0, "fill");
        check("full_tx_ready", tx_ready, 0);
        check("full_rx_valid", rx_valid, 1);
        check("full_log_len", log_q.size(), exp_log.size());
        n_before = log_q.size();
        fork
            send(16'($urandom), 1'b0);
            begin
                repeat (40) @(posedge clk);
                #1;
                check("no_5th_write", log_q.size(), n_before);
                check("full_hold_tx_ready", tx_ready, 0);
                rx_ready = 1'b1;
                @(posedge clk); #1;
                rx_ready = 1'b0;
            end
        join
        wait_idle(1'b0, "fifth");
        check("fifth_full", tx_ready, 0);
        rx_ready = 1'b1;
        wait_idle(1'b1, "fill_drain");
        check_log("fill");

        // streaming with consumer always ready
        miso_xor = 16'($urandom);
        for (int i = 0; i < 6; i++) send(16'($urandom), 1'b0);
        wait_idle(1'b1, "stream");
        check_log("stream");
        check("stream_toe", toe_m, 0);
        check("stream_roe", roe_m, 0);

        // reset during WR_DATA
        send(16'($urandom), 1'b0);
        t = 0;
        @(negedge clk);
        while (!(spi_write_n == 1'b0 && spi_mem_addr == 3'd1) && t < 3000) begin t++; @(negedge clk); end
        check("wr_seen_timeout", (t >= 3000), 0);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_write_n", spi_write_n, 1);
        check("mid_rst_select", spi_select, 0);
        check("mid_rst_busy", busy, 1);
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_rx_valid", rx_valid, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        log_q.delete(); exp_log.delete(); exp_rx.delete(); pkt_open = 1'b0;
        exp_log.push_back({1'b1, 3'd5, MASK});
        repeat (10) @(posedge clk); #1;
        check_log("reinit");
        check("reinit_busy", busy, 0);

        // three-word packet, last flagged on the third
        miso_xor = 16'($urandom);
        win_bt = n_txw; win_br = n_rd; ss_hi_cnt = 0; win_en = 1'b1;
        send(16'($urandom), 1'b0);
        send(16'($urandom), 1'b0);
        send(16'($urandom), 1'b1);
        wait_idle(1'b1, "pkt");
        win_en = 1'b0;
        check_log("pkt");
`ifdef SPI_SSO_HOLD_EN
        check("pkt_ss_high_cycles", ss_hi_cnt, 0);
        check("pkt_sso_cleared", ctrl_reg[10], 0);
`else
        check("pkt_ss_pulses", (ss_hi_cnt > 0), 1);
`endif
        check("pkt_toe", toe_m, 0);
        check("pkt_roe", roe_m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
